axil_regfile_slave: RTL and testbench
=====================================

# axil_regfile_slave

AXI4-Lite responder holding a bank of read/write control registers and read-only status registers for firmware access over the PS interconnect. Control registers drive fabric logic through a flat output vector with per-register write pulses; status words are sampled from fabric inputs on each read. It is the slave-side counterpart to the AXI VIP master sequences used in block-level benches, and answers their single-beat AXI4LITE_WRITE_BURST/READ_BURST traffic.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported
- C_S_AXI_ADDR_WIDTH, 8, byte address width; word index = addr[ADDR_WIDTH-1:2]
- N_CTRL, 32, number of RW control registers, word indices 0..N_CTRL-1
- N_STAT, 16, number of RO status registers, word indices N_CTRL..N_CTRL+N_STAT-1
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel; AWPROT ignored
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read address; ARPROT ignored
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data
- ctrl_out  out  32*N_CTRL  control register contents, register i at [32*i+31:32*i]
- ctrl_wr_pulse  out  N_CTRL  one-cycle strobe, bit i high the cycle after register i is written
- stat_in  in  32*N_STAT  status words, word j at [32*j+31:32*j], synchronous to ACLK

## Operation
- Write path FSM: WR_IDLE -> WR_RESP. In WR_IDLE, AWREADY high until address captured, WREADY high until data captured; AW and W accepted independently in any order or same cycle.
- Commit on the edge where the second of AW/W handshakes completes (or both together): decode, apply, load BRESP, set BVALID, enter WR_RESP.
- In WR_RESP: AWREADY=WREADY=0; hold BVALID/BRESP stable until BREADY; on handshake return to WR_IDLE.
- Decode: index < N_CTRL -> byte-lane update per WSTRB (strb 0 lanes unchanged), BRESP=OKAY, ctrl_wr_pulse[index] high for exactly the following cycle (also when WSTRB=0). Index in status range or >= N_CTRL+N_STAT -> no register change, no pulse, BRESP=SLVERR (2'b10).
- Read path FSM: RD_IDLE -> RD_RESP. ARREADY=1 in RD_IDLE; on AR handshake register RDATA/RRESP, set RVALID, enter RD_RESP; hold stable until RREADY, then RD_IDLE.
- Read data: control index -> current ctrl register; status index -> stat_in word sampled at the AR handshake edge; out-of-range -> RDATA=0xDEADBEEF, RRESP=SLVERR.
- Read and write paths fully independent; may be active concurrently.
- Address bits [1:0] ignored; unaligned addresses treated as the containing word.

## Timing
- Reset values: AWREADY=WREADY=ARREADY=0 while ARESET high, 1 from first edge after release; BVALID=RVALID=0; BRESP=RRESP=2'b00; RDATA=0; all ctrl registers 0; ctrl_wr_pulse=0; both FSMs idle.
- Write latency: commit at edge k -> BVALID high in cycle k+1; ctrl_out reflects new value in cycle k+1; ctrl_wr_pulse high in cycle k+1 only.
- Read latency: AR handshake at edge k -> RVALID high in cycle k+1.
- Throughput with BREADY/RREADY tied high: one write per 2 cycles, one read per 2 cycles.
- Same-cycle read AR handshake and write commit to the same register: read returns pre-write value.
- Back-pressure: BVALID/RVALID, BRESP/RRESP, RDATA never change while VALID high and READY low.
- ARESET asserted mid-transaction: all VALIDs/READYs drop immediately (asynchronously); partially captured AW or W discarded; no register update.

## Test plan
- Write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC (AW+W same cycle, BREADY=1) -> four OKAY responses, each BVALID one cycle after commit; read back same addresses -> RDATA 0x1..0x4, RRESP OKAY; ctrl_wr_pulse[0..3] each high for one cycle.
- Write 0xAABBCCDD to 0x10 then 0x11223344 with WSTRB=4'b0101 -> readback 0xAA22CC44.
- Drive stat_in word 0 = 0xCAFE0001, read address 4*N_CTRL (0x80) -> RDATA 0xCAFE0001 OKAY; write there -> SLVERR, readback unchanged.
- Read/write address 0xC0 (index 48, out of range with defaults) -> read 0xDEADBEEF SLVERR; write SLVERR, no ctrl_wr_pulse.
- AWVALID 3 cycles before WVALID, BREADY held low 5 cycles -> AWREADY drops after AW capture, commit on W handshake, BVALID/BRESP stable 5 cycles, AWREADY/WREADY return after B handshake.
- Assert ARESET with AW captured but W pending, then complete W after release -> no update, BVALID not asserted for orphan W until fresh AW; all ctrl_out read 0.

Source files
------------

// File: rtl/axil_regfile_slave.sv
`default_nettype none
// ============================================================================
// axil_regfile_slave : AXI4-Lite RW control / RO status register bank  (rev 1.0)
// ============================================================================
module axil_regfile_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int N_CTRL             = 32,
  parameter int N_STAT             = 16
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,
  output logic [1:0]                       S_AXI_BRESP,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic [2:0]                       S_AXI_ARPROT,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*N_CTRL-1:0] ctrl_out,
  output logic [N_CTRL-1:0]                ctrl_wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH*N_STAT-1:0] stat_in
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_RESP = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_RESP = 1'b1;

  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [DW-1:0] BAD_WORD    = 32'hDEADBEEF;

  logic [0:0]    wr_state, wr_next;
  logic [0:0]    rd_state, rd_next;
  logic          live;
  logic          aw_done, w_done;
  logic [IW-1:0] aw_idx;
  logic [DW-1:0] w_data;
  logic [NB-1:0] w_strb;
  logic [DW-1:0] ctrl_q [N_CTRL];

  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          wr_commit, wr_is_ctrl;
  logic [IW-1:0] cur_idx, rd_idx;
  logic [DW-1:0] cur_data, rd_word;
  logic [NB-1:0] cur_strb;
  logic          rd_err;
  logic [N_CTRL-1:0] wr_hit;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Keeps the READYs low until the first edge after reset release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) live <= 1'b0;
    else        live <= 1'b1;
  end

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign b_hs  = S_AXI_BVALID  && S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;

  // A channel handshaking this edge supplies its value directly; otherwise the held copy.
  assign cur_idx    = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx;
  assign cur_data   = w_hs  ? S_AXI_WDATA : w_data;
  assign cur_strb   = w_hs  ? S_AXI_WSTRB : w_strb;
  assign wr_commit  = (wr_state == WR_IDLE) && (aw_hs || aw_done) && (w_hs || w_done);
  assign wr_is_ctrl = int'(cur_idx) < N_CTRL;
  assign rd_idx     = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (wr_commit) wr_next = WR_RESP;
      WR_RESP: if (b_hs)      wr_next = WR_IDLE;
      default:                wr_next = WR_IDLE;
    endcase
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_RESP;
      RD_RESP: if (r_hs)  rd_next = RD_IDLE;
      default:            rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = live && (wr_state == WR_IDLE) && !aw_done;
    S_AXI_WREADY  = live && (wr_state == WR_IDLE) && !w_done;
    S_AXI_ARREADY = live && (rd_state == RD_IDLE);
  end

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < N_CTRL; i++)
      wr_hit[i] = wr_commit && wr_is_ctrl && (cur_idx == IW'(i));
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      aw_idx        <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      ctrl_wr_pulse <= '0;
      for (int i = 0; i < N_CTRL; i++) ctrl_q[i] <= '0;
    end else begin
      ctrl_wr_pulse <= wr_hit;
      if (aw_hs) begin
        aw_done <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_done <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (wr_commit) begin
        aw_done      <= 1'b0;
        w_done       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_is_ctrl ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        S_AXI_BVALID <= 1'b0;
      end
      for (int i = 0; i < N_CTRL; i++)
        for (int b = 0; b < NB; b++)
          if (wr_hit[i] && cur_strb[b]) ctrl_q[i][8*b +: 8] <= cur_data[8*b +: 8];
    end
  end

  always_comb begin
    rd_word = BAD_WORD;
    rd_err  = 1'b1;
    for (int i = 0; i < N_CTRL; i++)
      if (rd_idx == IW'(i)) begin
        rd_word = ctrl_q[i];
        rd_err  = 1'b0;
      end
    for (int j = 0; j < N_STAT; j++)
      if (rd_idx == IW'(N_CTRL + j)) begin
        rd_word = stat_in[DW*j +: DW];
        rd_err  = 1'b0;
      end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_word;
      S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CTRL; i++) begin : g_ctrl_out
    assign ctrl_out[DW*i +: DW] = ctrl_q[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_regfile_slave.sv
`default_nettype none
// ============================================================================
// tb_axil_regfile_slave : vector table + scoreboard bench for axil_regfile_slave
// ============================================================================
module tb_axil_regfile_slave;

  localparam int N_CTRL = 32;
  localparam int N_STAT = 16;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [7:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [7:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [32*N_CTRL-1:0] ctrl_out;
  logic [N_CTRL-1:0]    ctrl_wr_pulse;
  logic [32*N_STAT-1:0] stat_in = '0;

  axil_regfile_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8),
                       .N_CTRL(N_CTRL), .N_STAT(N_STAT)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ctrl_out(ctrl_out), .ctrl_wr_pulse(ctrl_wr_pulse), .stat_in(stat_in)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  exp_t wq[$];
  exp_t rq[$];
  vec_t vecs[$];
  logic [31:0] model [N_CTRL];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit wr, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] r, input logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.rdata = rd;
    vecs.push_back(v);
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic check_all_ctrl(input string name);
    int bad = 0;
    for (int i = 0; i < N_CTRL; i++)
      if (ctrl_out[32*i +: 32] !== model[i]) bad++;
    chk(name, bad, 0);
  endtask

  // Tasks start and end #1 after a rising edge.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp);
    exp_t e;
    int n, idx;
    logic awf, wf;
    logic [31:0] exp_pulse;
    e.resp = resp; e.data = '0;
    wq.push_back(e);
    idx = int'(addr[7:2]);
    exp_pulse = (idx < N_CTRL) ? (32'h1 << idx) : 32'h0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    n = 0;
    while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
      awf = S_AXI_AWVALID && S_AXI_AWREADY;
      wf  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (awf) S_AXI_AWVALID = 1'b0;
      if (wf)  S_AXI_WVALID  = 1'b0;
      n++;
    end
    chk("wr_accept_timeout", {31'b0, S_AXI_AWVALID | S_AXI_WVALID}, 32'h0);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("bvalid_after_commit", {31'b0, S_AXI_BVALID}, 32'h1);
    if (S_AXI_BVALID) begin
      e = wq.pop_front();
      chk("bresp", {30'b0, S_AXI_BRESP}, {30'b0, e.resp});
    end
    chk("wr_pulse", ctrl_wr_pulse, exp_pulse);
    if (idx < N_CTRL) begin
      model_write(idx, data, strb);
      chk("ctrl_out_word", ctrl_out[32*idx +: 32], model[idx]);
    end
    @(posedge ACLK); #1;
    chk("wr_pulse_clear", ctrl_wr_pulse, 32'h0);
    chk("bvalid_clear", {31'b0, S_AXI_BVALID}, 32'h0);
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] resp);
    exp_t e;
    int n;
    logic arf;
    e.resp = resp; e.data = data;
    rq.push_back(e);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    n = 0;
    while (S_AXI_ARVALID && n < 20) begin
      arf = S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (arf) S_AXI_ARVALID = 1'b0;
      n++;
    end
    chk("rd_accept_timeout", {31'b0, S_AXI_ARVALID}, 32'h0);
    S_AXI_ARVALID = 1'b0;
    chk("rvalid_after_ar", {31'b0, S_AXI_RVALID}, 32'h1);
    if (S_AXI_RVALID) begin
      e = rq.pop_front();
      chk("rdata", S_AXI_RDATA, e.data);
      chk("rresp", {30'b0, S_AXI_RRESP}, {30'b0, e.resp});
    end
    @(posedge ACLK); #1;
    chk("rvalid_clear", {31'b0, S_AXI_RVALID}, 32'h0);
  endtask

  initial begin
    exp_t e;
    int n;
    for (int i = 0; i < N_CTRL; i++) model[i] = '0;
    for (int j = 0; j < N_STAT; j++) stat_in[32*j +: 32] = 32'h5EA70000 + j;
    stat_in[31:0] = 32'hCAFE0001;

    // Reset state
    #12;
    chk("rst_awready", {31'b0, S_AXI_AWREADY}, 32'h0);
    chk("rst_wready",  {31'b0, S_AXI_WREADY},  32'h0);
    chk("rst_arready", {31'b0, S_AXI_ARREADY}, 32'h0);
    chk("rst_bvalid",  {31'b0, S_AXI_BVALID},  32'h0);
    chk("rst_rvalid",  {31'b0, S_AXI_RVALID},  32'h0);
    chk("rst_rdata",   S_AXI_RDATA, 32'h0);
    chk("rst_pulse",   ctrl_wr_pulse, 32'h0);
    check_all_ctrl("rst_ctrl_out");
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    chk("awready_before_edge", {31'b0, S_AXI_AWREADY}, 32'h0);
    @(posedge ACLK); #1;
    chk("awready_after_release", {31'b0, S_AXI_AWREADY}, 32'h1);
    chk("arready_after_release", {31'b0, S_AXI_ARREADY}, 32'h1);

    add(1, 8'h00, 32'h1, 4'hF, OK, 0);
    add(1, 8'h04, 32'h2, 4'hF, OK, 0);
    add(1, 8'h08, 32'h3, 4'hF, OK, 0);
    add(1, 8'h0C, 32'h4, 4'hF, OK, 0);
    add(0, 8'h00, 0, 0, OK, 32'h1);
    add(0, 8'h04, 0, 0, OK, 32'h2);
    add(0, 8'h08, 0, 0, OK, 32'h3);
    add(0, 8'h0C, 0, 0, OK, 32'h4);
    add(1, 8'h10, 32'hAABBCCDD, 4'hF, OK, 0);
    add(1, 8'h10, 32'h11223344, 4'b0101, OK, 0);
    add(0, 8'h10, 0, 0, OK, 32'hAA22CC44);
    add(0, 8'h80, 0, 0, OK, 32'hCAFE0001);
    add(1, 8'h80, 32'h12345678, 4'hF, ERR, 0);
    add(0, 8'h80, 0, 0, OK, 32'hCAFE0001);
    add(0, 8'hBC, 0, 0, OK, 32'h5EA7000F);
    add(0, 8'hC0, 0, 0, ERR, 32'hDEADBEEF);
    add(1, 8'hC0, 32'h9, 4'hF, ERR, 0);
    add(1, 8'h04, 32'hFFFFFFFF, 4'h0, OK, 0);
    add(0, 8'h04, 0, 0, OK, 32'h2);
    add(1, 8'h23, 32'h0BADF00D, 4'hF, OK, 0);
    add(0, 8'h21, 0, 0, OK, 32'h0BADF00D);
    add(1, 8'h7C, 32'h80000001, 4'b1001, OK, 0);
    add(0, 8'h7C, 0, 0, OK, 32'h80000001);

    foreach (vecs[k]) begin
      if (vecs[k].wr) do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].resp);
      else            do_read(vecs[k].addr, vecs[k].rdata, vecs[k].resp);
    end
    check_all_ctrl("ctrl_out_after_table");

    // Same-edge read and write commit to register 0: read sees the old value.
    S_AXI_AWADDR = 8'h00; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 8'h00;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    model_write(0, 32'h77, 4'hF);
    chk("rw_same_rvalid", {31'b0, S_AXI_RVALID}, 32'h1);
    chk("rw_same_rdata_old", S_AXI_RDATA, 32'h1);
    chk("rw_same_bvalid", {31'b0, S_AXI_BVALID}, 32'h1);
    chk("rw_same_ctrl_new", ctrl_out[31:0], 32'h77);
    @(posedge ACLK); #1;

    // AW three cycles ahead of W, then BREADY held low for five cycles.
    e.resp = OK; e.data = '0; wq.push_back(e);
    S_AXI_AWADDR = 8'h14; S_AXI_WDATA = 32'h55AA55AA; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b0;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    chk("aw_early_awready_drop", {31'b0, S_AXI_AWREADY}, 32'h0);
    chk("aw_early_wready_wait",  {31'b0, S_AXI_WREADY},  32'h1);
    repeat (2) begin
      @(posedge ACLK); #1;
      chk("aw_early_no_bvalid", {31'b0, S_AXI_BVALID}, 32'h0);
    end
    S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    model_write(5, 32'h55AA55AA, 4'hF);
    chk("bp_pulse", ctrl_wr_pulse, 32'h1 << 5);
    chk("bp_ctrl_word", ctrl_out[32*5 +: 32], model[5]);
    if (S_AXI_BVALID) begin
      e = wq.pop_front();
      chk("bp_bresp_first", {30'b0, S_AXI_BRESP}, {30'b0, e.resp});
    end
    for (int c = 0; c < 5; c++) begin
      chk("bp_bvalid_hold", {31'b0, S_AXI_BVALID}, 32'h1);
      chk("bp_bresp_hold",  {30'b0, S_AXI_BRESP},  {30'b0, OK});
      chk("bp_ready_low",   {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h0);
      @(posedge ACLK); #1;
    end
    chk("bp_pulse_single", ctrl_wr_pulse, 32'h0);
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    chk("bp_bvalid_clear", {31'b0, S_AXI_BVALID}, 32'h0);
    chk("bp_ready_return", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h3);

    // Reset with AW captured and W pending; orphan W afterwards waits for a fresh AW.
    S_AXI_AWADDR = 8'h18; S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    chk("orph_aw_captured", {31'b0, S_AXI_AWREADY}, 32'h0);
    #2 ARESET = 1'b1;
    #1;
    chk("async_rst_ready", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h0);
    chk("async_rst_valid", {30'b0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    for (int i = 0; i < N_CTRL; i++) model[i] = '0;
    @(posedge ACLK); #1;
    S_AXI_WDATA = 32'h5A5A5A5A; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    n = 0;
    while (S_AXI_WVALID && n < 20) begin
      if (S_AXI_WREADY) begin
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
      end else begin
        @(posedge ACLK); #1;
      end
      n++;
    end
    chk("orph_w_accept", {31'b0, S_AXI_WVALID}, 32'h0);
    S_AXI_WVALID = 1'b0;
    repeat (4) begin
      chk("orph_no_bvalid", {31'b0, S_AXI_BVALID}, 32'h0);
      @(posedge ACLK); #1;
    end
    check_all_ctrl("orph_ctrl_zero");
    chk("orph_no_pulse", ctrl_wr_pulse, 32'h0);
    e.resp = OK; e.data = '0; wq.push_back(e);
    S_AXI_AWADDR = 8'h18; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    model_write(6, 32'h5A5A5A5A, 4'hF);
    chk("fresh_aw_bvalid", {31'b0, S_AXI_BVALID}, 32'h1);
    if (S_AXI_BVALID) begin
      e = wq.pop_front();
      chk("fresh_aw_bresp", {30'b0, S_AXI_BRESP}, {30'b0, e.resp});
    end
    chk("fresh_aw_pulse", ctrl_wr_pulse, 32'h1 << 6);
    @(posedge ACLK); #1;
    check_all_ctrl("final_ctrl_out");
    do_read(8'h18, 32'h5A5A5A5A, OK);
    do_read(8'h00, 32'h0, OK);

    chk("wq_drained", wq.size(), 32'h0);
    chk("rq_drained", rq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
